// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds decoded control and operands for EX, with valid/ready
// handshake, branch flush, load-use bubble insertion and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic [1:0]            id_alu_op,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_funct,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic [1:0]            ex_alu_op,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [3:0]            ex_funct,
    output logic                  hazard_stall,
    output logic [CNT_W-1:0]      bubble_count
);

    // Control vector layout: {branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
    localparam int CTRL_W        = 8;
    localparam int CTRL_MEM_READ = 6;

    logic                  r_valid;
    logic [CTRL_W-1:0]     r_ctrl;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       r_rs1_data;
    logic [XLEN-1:0]       r_rs2_data;
    logic [XLEN-1:0]       r_imm;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [3:0]            r_funct;
    logic [CNT_W-1:0]      r_bcnt;

    logic                  w_adv;
    logic                  w_uses_rs2;
    logic                  w_hazard;
    logic [CTRL_W-1:0]     w_id_ctrl;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_id_ctrl  = {id_branch, id_mem_read, id_mem_to_reg, id_alu_op,
                         id_mem_write, id_alu_src, id_reg_write};
    assign w_adv      = ~r_valid | ex_ready;
    // Stores read rs2 for the data even though alu_src selects the immediate.
    assign w_uses_rs2 = ~id_alu_src | id_mem_write;
    assign w_hazard   = id_valid & r_valid & r_ctrl[CTRL_MEM_READ] & (r_rd != '0) &
                        ((r_rd == id_rs1) | (w_uses_rs2 & (r_rd == id_rs2)));

    assign hazard_stall = w_hazard;
    assign id_ready     = w_adv & ~w_hazard & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct    <= '0;
            r_bcnt     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_adv) begin
            if (w_hazard) begin
                // Bubble: data fields are left as-is, only control is killed.
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_bcnt  <= sat_inc(r_bcnt);
            end else if (id_valid) begin
                r_valid    <= 1'b1;
                r_ctrl     <= w_id_ctrl;
                r_pc       <= id_pc;
                r_rs1_data <= id_rs1_data;
                r_rs2_data <= id_rs2_data;
                r_imm      <= id_imm;
                r_rs1      <= id_rs1;
                r_rs2      <= id_rs2;
                r_rd       <= id_rd;
                r_funct    <= id_funct;
            end else begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end
        end
    end

    assign ex_valid = r_valid;
    assign {ex_branch, ex_mem_read, ex_mem_to_reg, ex_alu_op,
            ex_mem_write, ex_alu_src, ex_reg_write} = r_ctrl;
    assign ex_pc        = r_pc;
    assign ex_rs1_data  = r_rs1_data;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_imm       = r_imm;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_rd        = r_rd;
    assign ex_funct     = r_funct;
    assign bubble_count = r_bcnt;

endmodule
